// File: rtl/hex_blink_decoder_pkg.sv
// Shared types and constants for the HELLO display driver and its blink decoder.
// Segment patterns are active-low, segments a..g on bits [0:6].
package hex_blink_decoder_pkg;

    typedef logic [0:6] seg_t;
    typedef logic [2:0] char_t;
    typedef logic [1:0] rate_t;

    localparam seg_t SEG_H     = 7'b1001000;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_L     = 7'b1110001;
    localparam seg_t SEG_O     = 7'b0000001;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam char_t CHAR_NONE    = 3'd0;
    localparam char_t CHAR_H       = 3'd1;
    localparam char_t CHAR_E       = 3'd2;
    localparam char_t CHAR_L       = 3'd3;
    localparam char_t CHAR_O       = 3'd4;
    localparam char_t CHAR_INVALID = 3'd7;

    localparam rate_t RATE_1HZ = 2'b00;
    localparam rate_t RATE_2HZ = 2'b01;
    localparam rate_t RATE_4HZ = 2'b10;
    localparam rate_t RATE_8HZ = 2'b11;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Map a lit pattern to its character code; anything unrecognised is invalid.
    function automatic char_t decode_seg(seg_t pat);
        char_t code;
        case (pat)
            SEG_H:   code = CHAR_H;
            SEG_E:   code = CHAR_E;
            SEG_L:   code = CHAR_L;
            SEG_O:   code = CHAR_O;
            default: code = CHAR_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hex_blink_decoder_if.sv
// Digit bus and status outputs between the display under test and the blink decoder.
interface hex_blink_decoder_if;
    import hex_blink_decoder_pkg::*;

    seg_t  HEX_IN;
    char_t CHAR;
    rate_t RATE;
    logic  RATE_VALID;
    logic  BLINK_ERR;

    modport master (output HEX_IN, input CHAR, RATE, RATE_VALID, BLINK_ERR);
    modport slave  (input HEX_IN, output CHAR, RATE, RATE_VALID, BLINK_ERR);

endinterface

// File: rtl/hex_lit_sync.sv
// Two-flop synchronizer for the segment bus, plus lit tracking and lit-change detection.
module hex_lit_sync
    import hex_blink_decoder_pkg::*;
(
    input  logic CLOCK_50,
    input  logic KEY0,
    input  seg_t pat_in,
    output seg_t pat_sync,
    output logic edge_c
);

    seg_t s1_q;
    seg_t s2_q;
    logic lit_q;
    logic lit_qq;

    // Sync flops reset to blank so a lit display after reset is seen as an edge.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            s1_q   <= SEG_BLANK;
            s2_q   <= SEG_BLANK;
            lit_q  <= 1'b0;
            lit_qq <= 1'b0;
        end else begin
            s1_q   <= pat_in;
            s2_q   <= s1_q;
            lit_q  <= (s2_q != SEG_BLANK);
            lit_qq <= lit_q;
        end
    end

    assign pat_sync = s2_q;
    assign edge_c   = lit_q ^ lit_qq;

endmodule

// File: rtl/hex_blink_decoder.sv
// Blink decoder: recovers the displayed character and the blink-rate code of a
// single 7-segment digit by measuring the lit/blank half-period.
module hex_blink_decoder
    import hex_blink_decoder_pkg::*;
#(
    parameter int unsigned BASE_LOG2 = 22
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    hex_blink_decoder_if.slave  bus
);

    localparam int unsigned HP_W = BASE_LOG2 + 4;

    localparam logic [HP_W-1:0] WIN_8HZ = HP_W'(3 << (BASE_LOG2 - 2));
    localparam logic [HP_W-1:0] WIN_4HZ = HP_W'(3 << (BASE_LOG2 - 1));
    localparam logic [HP_W-1:0] WIN_2HZ = HP_W'(3 << BASE_LOG2);
    localparam logic [HP_W-1:0] WIN_1HZ = HP_W'(3 << (BASE_LOG2 + 1));
    localparam logic [HP_W-1:0] TMO     = HP_W'(3 << (BASE_LOG2 + 2));

    seg_t            pat_sync;
    logic            edge_c;
    state_t          state_q;
    logic [HP_W-1:0] hp_q;
    rate_t           cand_q;
    logic            cand_vld_q;
    rate_t           rate_q;
    logic            rate_valid_q;
    logic            blink_err_q;
    char_t           char_q;
    rate_t           cls_c;
    logic            cls_ok_c;

    hex_lit_sync u_sync (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .pat_in   (bus.HEX_IN),
        .pat_sync (pat_sync),
        .edge_c   (edge_c)
    );

    // Character register holds through blank phases.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            char_q <= CHAR_NONE;
        end else if (pat_sync != SEG_BLANK) begin
            char_q <= decode_seg(pat_sync);
        end
    end

    // Rate window lookup for the half-period ending at this edge.
    always_comb begin
        cls_c    = RATE_1HZ;
        cls_ok_c = 1'b1;
        if (hp_q >= WIN_8HZ && hp_q < WIN_4HZ) begin
            cls_c = RATE_8HZ;
        end else if (hp_q >= WIN_4HZ && hp_q < WIN_2HZ) begin
            cls_c = RATE_4HZ;
        end else if (hp_q >= WIN_2HZ && hp_q < WIN_1HZ) begin
            cls_c = RATE_2HZ;
        end else if (hp_q >= WIN_1HZ && hp_q < TMO) begin
            cls_c = RATE_1HZ;
        end else begin
            cls_ok_c = 1'b0;
        end
    end

    // Half-period counter and lock FSM; an edge takes priority over a timeout.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q      <= ST_SEARCH;
            hp_q         <= '0;
            cand_q       <= RATE_1HZ;
            cand_vld_q   <= 1'b0;
            rate_q       <= RATE_1HZ;
            rate_valid_q <= 1'b0;
            blink_err_q  <= 1'b0;
        end else begin
            blink_err_q <= 1'b0;

            if (edge_c) begin
                hp_q <= HP_W'(1);
            end else if (hp_q != TMO) begin
                hp_q <= hp_q + HP_W'(1);
            end

            case (state_q)
                ST_SEARCH: begin
                    if (edge_c) begin
                        state_q    <= ST_TRACK;
                        cand_vld_q <= 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (edge_c) begin
                        if (!cls_ok_c) begin
                            blink_err_q <= 1'b1;
                            cand_vld_q  <= 1'b0;
                        end else if (cand_vld_q && cand_q == cls_c) begin
                            state_q      <= ST_LOCKED;
                            rate_q       <= cls_c;
                            rate_valid_q <= 1'b1;
                        end else begin
                            cand_q     <= cls_c;
                            cand_vld_q <= 1'b1;
                        end
                    end else if (hp_q == TMO) begin
                        state_q    <= ST_SEARCH;
                        cand_vld_q <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_c) begin
                        if (!cls_ok_c) begin
                            blink_err_q  <= 1'b1;
                            state_q      <= ST_TRACK;
                            cand_vld_q   <= 1'b0;
                            rate_valid_q <= 1'b0;
                        end else if (cls_c != rate_q) begin
                            state_q      <= ST_TRACK;
                            cand_q       <= cls_c;
                            cand_vld_q   <= 1'b1;
                            rate_valid_q <= 1'b0;
                        end
                    end else if (hp_q == TMO) begin
                        state_q      <= ST_SEARCH;
                        cand_vld_q   <= 1'b0;
                        rate_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_SEARCH;
                    cand_vld_q   <= 1'b0;
                    rate_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CHAR       = char_q;
    assign bus.RATE       = rate_q;
    assign bus.RATE_VALID = rate_valid_q;
    assign bus.BLINK_ERR  = blink_err_q;

endmodule

// File: tb/tb_hex_blink_decoder.sv
// Bench for hex_blink_decoder (BASE_LOG2=4): event-level model of the blink
// rules compared every cycle, plus hand-computed literal expectations.
module tb_hex_blink_decoder;

    localparam int B   = 4;
    localparam int TMO = 3 * (2 ** (B + 2));

    localparam logic [0:6] P_H   = 7'b1001000;
    localparam logic [0:6] P_E   = 7'b0110000;
    localparam logic [0:6] P_L   = 7'b1110001;
    localparam logic [0:6] P_O   = 7'b0000001;
    localparam logic [0:6] P_BAD = 7'b0000000;
    localparam logic [0:6] P_BL  = 7'b1111111;

    logic CLOCK_50 = 1'b0;
    logic KEY0     = 1'b1;

    hex_blink_decoder_if bus ();

    hex_blink_decoder #(.BASE_LOG2(B)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_total  = 0;
    int n_pass   = 0;
    int err_seen = 0;
    bit cmp_en   = 1'b0;

    // Model: 0 search, 1 tracking, 2 locked; cand -1 = none.
    int m_char  = 0;
    int m_rate  = 0;
    int m_valid = 0;
    int m_err   = 0;
    int m_st    = 0;
    int m_cand  = -1;
    int m_last  = 0;
    int m_cyc   = 0;
    bit m_plit  = 1'b0;
    int edge_q[$];
    int chr_t[$];
    int chr_v[$];

    function automatic int decode(logic [0:6] p);
        if (p == P_H) return 1;
        if (p == P_E) return 2;
        if (p == P_L) return 3;
        if (p == P_O) return 4;
        return 7;
    endfunction

    function automatic int classify(int g);
        if (g >= 3 * (2 ** (B - 2)) && g < 3 * (2 ** (B - 1))) return 3;
        if (g >= 3 * (2 ** (B - 1)) && g < 3 * (2 ** B))       return 2;
        if (g >= 3 * (2 ** B)       && g < 3 * (2 ** (B + 1))) return 1;
        if (g >= 3 * (2 ** (B + 1)) && g < TMO)                return 0;
        return -1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Lit changes take effect on outputs 3 clocks after first sampled; chars 2 clocks.
    initial forever begin
        @(posedge CLOCK_50 or negedge KEY0);
        if (!KEY0) begin
            m_char = 0; m_rate = 0; m_valid = 0; m_err = 0;
            m_st = 0; m_cand = -1; m_plit = 1'b0;
            edge_q.delete(); chr_t.delete(); chr_v.delete();
        end else begin
            bit lit;
            m_cyc++;
            m_err = 0;
            lit = (bus.HEX_IN != P_BL);
            if (lit) begin
                chr_t.push_back(m_cyc + 2);
                chr_v.push_back(decode(bus.HEX_IN));
            end
            if (lit != m_plit) edge_q.push_back(m_cyc);
            m_plit = lit;
            if (chr_t.size() > 0 && chr_t[0] == m_cyc) begin
                m_char = chr_v[0];
                void'(chr_t.pop_front());
                void'(chr_v.pop_front());
            end
            if (edge_q.size() > 0 && edge_q[0] + 3 == m_cyc) begin
                int j, c;
                j = edge_q.pop_front();
                c = classify(j - m_last);
                m_last = j;
                if (m_st == 0) begin
                    m_st = 1; m_cand = -1;
                end else if (c < 0) begin
                    m_err = 1; m_st = 1; m_cand = -1; m_valid = 0;
                end else if (m_st == 2) begin
                    if (c != m_rate) begin
                        m_st = 1; m_cand = c; m_valid = 0;
                    end
                end else if (c == m_cand) begin
                    m_st = 2; m_rate = c; m_valid = 1;
                end else begin
                    m_cand = c;
                end
            end else if (m_st != 0 && m_cyc == m_last + TMO + 3) begin
                m_st = 0; m_cand = -1; m_valid = 0;
            end
        end
    end

    initial begin
        wait (cmp_en);
        forever begin
            @(negedge CLOCK_50);
            check("char",  int'(bus.CHAR),       m_char);
            check("rate",  int'(bus.RATE),       m_rate);
            check("valid", int'(bus.RATE_VALID), m_valid);
            check("err",   int'(bus.BLINK_ERR),  m_err);
            if (bus.BLINK_ERR) err_seen++;
        end
    end

    task automatic hold(logic [0:6] p, int n);
        bus.HEX_IN = p;
        repeat (n) @(negedge CLOCK_50);
        #1;
    endtask

    task automatic blink(logic [0:6] p, int hp, int halves);
        for (int i = 0; i < halves; i++) hold((i % 2 == 0) ? p : P_BL, hp);
    endtask

    initial begin
        int e0;
        bus.HEX_IN = P_BL;
        #1 KEY0 = 1'b0;
        #1;
        check("rst_char",  int'(bus.CHAR), 0);
        check("rst_valid", int'(bus.RATE_VALID), 0);
        cmp_en = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        #1 KEY0 = 1'b1;

        // Rate 11 at half-period 16
        blink(P_O, 16, 8);
        check("t1_char",  int'(bus.CHAR), 4);
        check("t1_valid", int'(bus.RATE_VALID), 1);
        check("t1_rate",  int'(bus.RATE), 3);

        // Switch to half-period 128: drop, then relock at 00
        blink(P_O, 128, 2);
        check("t2_drop", int'(bus.RATE_VALID), 0);
        blink(P_O, 128, 2);
        check("t2_valid", int'(bus.RATE_VALID), 1);
        check("t2_rate",  int'(bus.RATE), 0);
        check("t2_noerr", err_seen, 0);

        // Steady blank: timeout back to search
        hold(P_BL, 250);
        check("idle_valid", int'(bus.RATE_VALID), 0);

        // Half-period 8 is below every window
        e0 = err_seen;
        blink(P_E, 8, 6);
        check("t3_errs",  err_seen - e0, 5);
        check("t3_valid", int'(bus.RATE_VALID), 0);

        // Lock at 64, then a steady H display times out
        blink(P_L, 64, 4);
        check("t4_lock", int'(bus.RATE_VALID), 1);
        hold(P_H, 200);
        check("t4_valid", int'(bus.RATE_VALID), 0);
        check("t4_char",  int'(bus.CHAR), 1);
        check("t4_rate",  int'(bus.RATE), 1);

        // Character decode sequence
        hold(P_H, 20);   check("c_h",   int'(bus.CHAR), 1);
        hold(P_E, 20);   check("c_e",   int'(bus.CHAR), 2);
        hold(P_L, 20);   check("c_l",   int'(bus.CHAR), 3);
        hold(P_O, 20);   check("c_o",   int'(bus.CHAR), 4);
        hold(P_BAD, 20); check("c_bad", int'(bus.CHAR), 7);

        // Lock at 32, then asynchronous reset mid-operation
        hold(P_BL, 20);
        blink(P_O, 32, 6);
        check("t6_valid", int'(bus.RATE_VALID), 1);
        check("t6_rate",  int'(bus.RATE), 2);
        bus.HEX_IN = P_O;
        KEY0 = 1'b0;
        #1;
        check("ar_char",  int'(bus.CHAR), 0);
        check("ar_rate",  int'(bus.RATE), 0);
        check("ar_valid", int'(bus.RATE_VALID), 0);
        check("ar_err",   int'(bus.BLINK_ERR), 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        #1 KEY0 = 1'b1;
        hold(P_O, 32);
        hold(P_BL, 32);
        check("t6_two_edges", int'(bus.RATE_VALID), 0);
        hold(P_O, 32);
        check("t6_relock", int'(bus.RATE_VALID), 1);
        check("t6_rerate", int'(bus.RATE), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
